// File: rtl/kamus_fetch_ctrl.sv
// kamus_fetch_ctrl: IF-stage fetch sequencer.
// Owns the PC, issues single-outstanding requests to the L1I, buffers
// responses in a 2-entry FIFO toward ID and squashes stale data on redirect.
module kamus_fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_val_o,
    output logic [31:0] instr_addr_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_pc, w_pc_nxt;
    logic [31:0]      r_req_addr, w_req_addr_nxt;  // address of the request in REQ/WAIT
    logic             r_discard, w_discard_nxt;    // in-flight response belongs to an old path
    logic [1:0][31:0] r_q_addr, r_q_data;          // entry 0 is the head
    logic [1:0]       r_count, w_count_nxt;
    logic             w_push, w_pop;
    logic [31:0]      w_redir_pc;

    assign w_redir_pc    = redirect_addr_i & 32'hFFFF_FFFC;
    assign w_push        = (r_state == S_WAIT) && imem_rvalid_i && !r_discard && !redirect_valid_i;
    assign w_pop         = instr_valid_o && instr_ready_i;
    assign instr_valid_o = (r_count != 2'd0);
    assign instr_val_o   = r_q_data[0];
    assign instr_addr_o  = r_q_addr[0];

    // queue occupancy after this cycle; a redirect empties it outright
    always_comb begin
        w_count_nxt = r_count;
        if (redirect_valid_i)
            w_count_nxt = 2'd0;
        else if (w_push && !w_pop)
            w_count_nxt = r_count + 2'd1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 2'd1;
    end

    // next-state, PC update and request outputs; a response cycle may also
    // launch the next request so fetch can stream back-to-back
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_discard_nxt  = r_discard;
        imem_req_o     = 1'b0;
        imem_addr_o    = r_pc;
        if (redirect_valid_i)
            w_pc_nxt = w_redir_pc;
        unique case (r_state)
            S_IDLE: begin
                if (fetch_en_i && (w_count_nxt < 2'd2)) begin
                    w_state_nxt    = S_REQ;
                    w_req_addr_nxt = w_pc_nxt;
                end
            end
            S_REQ: begin
                // an ungranted request must stay stable, so a redirect only marks it stale
                imem_req_o  = 1'b1;
                imem_addr_o = r_req_addr;
                if (redirect_valid_i)
                    w_discard_nxt = 1'b1;
                if (imem_gnt_i) begin
                    w_state_nxt = S_WAIT;
                    if (!redirect_valid_i && !r_discard)
                        w_pc_nxt = r_pc + 32'd4;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    w_discard_nxt = 1'b0;
                    if (!fetch_en_i || (w_count_nxt == 2'd2)) begin
                        w_state_nxt = S_IDLE;
                    end else if (redirect_valid_i) begin
                        w_state_nxt    = S_REQ;
                        w_req_addr_nxt = w_pc_nxt;
                    end else begin
                        imem_req_o     = 1'b1;
                        w_req_addr_nxt = r_pc;
                        if (imem_gnt_i) begin
                            w_state_nxt = S_WAIT;
                            w_pc_nxt    = r_pc + 32'd4;
                        end else begin
                            w_state_nxt = S_REQ;
                        end
                    end
                end else if (redirect_valid_i) begin
                    w_discard_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // fetch state, PC and in-flight request bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_pc       <= BOOT_ADDR;
            r_req_addr <= BOOT_ADDR;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    // 2-entry instruction FIFO; the response address is the request's PC
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count  <= 2'd0;
            r_q_addr <= '0;
            r_q_data <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (!redirect_valid_i) begin
                if (w_pop) begin
                    r_q_addr[0] <= r_q_addr[1];
                    r_q_data[0] <= r_q_data[1];
                    if (w_push) begin
                        if (r_count == 2'd1) begin
                            r_q_addr[0] <= r_req_addr;
                            r_q_data[0] <= imem_rdata_i;
                        end else begin
                            r_q_addr[1] <= r_req_addr;
                            r_q_data[1] <= imem_rdata_i;
                        end
                    end
                end else if (w_push) begin
                    if (r_count == 2'd0) begin
                        r_q_addr[0] <= r_req_addr;
                        r_q_data[0] <= imem_rdata_i;
                    end else begin
                        r_q_addr[1] <= r_req_addr;
                        r_q_data[1] <= imem_rdata_i;
                    end
                end
            end
        end
    end
endmodule
